rvv_cmd_queue: RTL and testbench

Parametrised multi-port command queue between the RVV frontend and rvv_backend, replacing the fixed MultiFifo-plus-glue arrangement. It accepts up to NUM_IN commands per cycle by count and presents up to NUM_OUT head entries as per-lane valid/ready. It generates the frontend credit (capacity) with a configurable reserve and grant cap, and supports flush and a sticky overflow error.

---
 rtl/rvv_cmd_queue_pkg.sv | 30 +++
 rtl/rvv_lane_prefix_count.sv | 24 ++
 rtl/rvv_cmd_queue.sv | 131 +++++++++++++
 tb/tb_rvv_cmd_queue.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/rvv_cmd_queue_pkg.sv
// Shared constants and arithmetic helpers for the RVV command queue and its credit consumers.
// Pointer wrap is done by compare-subtract so DEPTH need not be a power of two.
package rvv_cmd_queue_pkg;

   localparam int unsigned CMDQ_NUM_IN    = 4;
   localparam int unsigned CMDQ_DEPTH     = 16;
   localparam int unsigned CMDQ_RESERVE   = CMDQ_NUM_IN;
   localparam int unsigned CMDQ_MAX_GRANT = 2 * CMDQ_NUM_IN;
   localparam int unsigned CMDQ_CAP_W     = $clog2(CMDQ_MAX_GRANT + 1);

   typedef logic [CMDQ_CAP_W-1:0] cmdq_credit_t;

   // Callers guarantee step <= depth, so one conditional subtract is enough.
   function automatic int unsigned wrap_inc(input int unsigned ptr,
                                            input int unsigned step,
                                            input int unsigned depth);
      int unsigned sum;
      sum = ptr + step;
      return (sum >= depth) ? sum - depth : sum;
   endfunction

   function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
      return (a < b) ? a : b;
   endfunction

   function automatic int unsigned sat_sub(input int unsigned a, input int unsigned b);
      return (a > b) ? a - b : 0;
   endfunction

endpackage

// File: rtl/rvv_lane_prefix_count.sv
// Counts the contiguous run of lanes, starting at lane 0, that have both valid and ready.
// A handshake on lane j only counts when every lower lane also handshakes.
module rvv_lane_prefix_count #(
   parameter int unsigned NUM_LANES = 2
) (
   input  logic [NUM_LANES-1:0]             i_valid,
   input  logic [NUM_LANES-1:0]             i_ready,
   output logic [$clog2(NUM_LANES+1)-1:0]   o_count
);

   localparam int unsigned CNT_W = $clog2(NUM_LANES + 1);

   logic w_run;

   always_comb begin
      w_run   = 1'b1;
      o_count = '0;
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
         w_run   = w_run & i_valid[i] & i_ready[i];
         o_count = o_count + CNT_W'(w_run);
      end
   end

endmodule

// File: rtl/rvv_cmd_queue.sv
// Multi-port command queue between the RVV frontend and backend: count-based enqueue,
// per-lane valid/ready dequeue, credit generation, flush and a sticky overflow flag.
module rvv_cmd_queue
   import rvv_cmd_queue_pkg::*;
#(
   parameter int unsigned DATA_W    = 128,
   parameter int unsigned NUM_IN    = CMDQ_NUM_IN,
   parameter int unsigned NUM_OUT   = 2,
   parameter int unsigned DEPTH     = CMDQ_DEPTH,
   parameter int unsigned RESERVE   = CMDQ_RESERVE,
   parameter int unsigned MAX_GRANT = CMDQ_MAX_GRANT
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            flush_i,
   input  logic [$clog2(NUM_IN+1)-1:0]     enq_count_i,
   input  logic [NUM_IN*DATA_W-1:0]        enq_data_i,
   output logic [NUM_OUT-1:0]              deq_valid_o,
   output logic [NUM_OUT*DATA_W-1:0]       deq_data_o,
   input  logic [NUM_OUT-1:0]              deq_ready_i,
   output logic [$clog2(DEPTH+1)-1:0]      fill_level_o,
   output logic [$clog2(MAX_GRANT+1)-1:0]  capacity_o,
   output logic                            empty_o,
   output logic                            full_o,
   output logic                            overflow_err_o
);

   localparam int unsigned OUT_W  = $clog2(NUM_OUT + 1);
   localparam int unsigned FILL_W = $clog2(DEPTH + 1);
   localparam int unsigned CAP_W  = $clog2(MAX_GRANT + 1);
   localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   if (DEPTH < NUM_IN + NUM_OUT) begin : g_bad_depth
      $error("rvv_cmd_queue: DEPTH must be >= NUM_IN + NUM_OUT");
   end
   if (RESERVE >= DEPTH) begin : g_bad_reserve
      $error("rvv_cmd_queue: RESERVE must be < DEPTH");
   end
   if (MAX_GRANT < 1) begin : g_bad_grant
      $error("rvv_cmd_queue: MAX_GRANT must be >= 1");
   end

   logic [DATA_W-1:0] r_mem [DEPTH];

   logic [PTR_W-1:0]  r_head;
   logic [PTR_W-1:0]  r_tail;
   logic [FILL_W-1:0] r_fill;
   logic              r_ovf;

   logic [PTR_W-1:0]  w_head_nxt;
   logic [PTR_W-1:0]  w_tail_nxt;
   logic [FILL_W-1:0] w_fill_nxt;
   logic              w_ovf_nxt;

   int unsigned       w_free;
   int unsigned       w_enq_acc;
   logic [OUT_W-1:0]  w_deq_acc;
   logic [PTR_W-1:0]  w_wr_idx [NUM_IN];
   logic [NUM_IN-1:0] w_wr_en;
   logic [PTR_W-1:0]  w_rd_idx [NUM_OUT];

   // Free space comes from the registered fill only; same-cycle dequeues never make room.
   always_comb begin
      w_free    = DEPTH - 32'(r_fill);
      w_enq_acc = min_u(32'(enq_count_i), w_free);
      for (int unsigned i = 0; i < NUM_IN; i++) begin
         w_wr_idx[i] = PTR_W'(wrap_inc(32'(r_tail), i, DEPTH));
         w_wr_en[i]  = !flush_i && (i < w_enq_acc);
      end
   end

   always_comb begin
      deq_valid_o = '0;
      deq_data_o  = '0;
      for (int unsigned i = 0; i < NUM_OUT; i++) begin
         w_rd_idx[i]                       = PTR_W'(wrap_inc(32'(r_head), i, DEPTH));
         deq_valid_o[i]                    = (i < 32'(r_fill));
         deq_data_o[i*DATA_W +: DATA_W]    = r_mem[w_rd_idx[i]];
      end
   end

   rvv_lane_prefix_count #(
      .NUM_LANES (NUM_OUT)
   ) u_deq_prefix (
      .i_valid (deq_valid_o),
      .i_ready (deq_ready_i),
      .o_count (w_deq_acc)
   );

   // Flush wins over both directions and drops enqueues without flagging overflow.
   always_comb begin
      w_head_nxt = PTR_W'(wrap_inc(32'(r_head), 32'(w_deq_acc), DEPTH));
      w_tail_nxt = PTR_W'(wrap_inc(32'(r_tail), w_enq_acc, DEPTH));
      w_fill_nxt = FILL_W'(32'(r_fill) - 32'(w_deq_acc) + w_enq_acc);
      w_ovf_nxt  = r_ovf | (!flush_i && (32'(enq_count_i) > w_free));
      if (flush_i) begin
         w_head_nxt = '0;
         w_tail_nxt = '0;
         w_fill_nxt = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_head <= '0;
         r_tail <= '0;
         r_fill <= '0;
         r_ovf  <= 1'b0;
      end else begin
         r_head <= w_head_nxt;
         r_tail <= w_tail_nxt;
         r_fill <= w_fill_nxt;
         r_ovf  <= w_ovf_nxt;
      end
   end

   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < NUM_IN; i++) begin
         if (w_wr_en[i]) begin
            r_mem[w_wr_idx[i]] <= enq_data_i[i*DATA_W +: DATA_W];
         end
      end
   end

   assign fill_level_o   = r_fill;
   assign empty_o        = (r_fill == '0);
   assign full_o         = (r_fill == FILL_W'(DEPTH));
   assign overflow_err_o = r_ovf;
   assign capacity_o     = CAP_W'(min_u(MAX_GRANT, sat_sub(DEPTH - RESERVE, 32'(r_fill))));

endmodule

// File: tb/tb_rvv_cmd_queue.sv
// Scoreboard bench for rvv_cmd_queue: identical stimulus drives a DEPTH=16 and a DEPTH=13
// instance, each with its own expected-entry queue.
module tb_rvv_cmd_queue;

   localparam int DW = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         flush;
   logic [2:0]   enq_cnt;
   logic [127:0] enq_data;
   logic [1:0]   rdy;

   logic [1:0]   v16, v13;
   logic [63:0]  d16, d13;
   logic [4:0]   f16;
   logic [3:0]   f13;
   logic [3:0]   c16, c13;
   logic         e16, e13, fu16, fu13, o16, o13;

   logic [DW-1:0] sb_q [2][$];
   int            pend_pop [2];
   int            n_pop [2];
   logic          exp_ovf [2];
   int            n_chk = 0;
   int            n_err = 0;
   bit            mon_en = 1'b0;

   always #5 clk = ~clk;

   rvv_cmd_queue #(.DATA_W(DW), .DEPTH(16)) u_dut16 (
      .clk(clk), .rst(rst), .flush_i(flush), .enq_count_i(enq_cnt), .enq_data_i(enq_data),
      .deq_valid_o(v16), .deq_data_o(d16), .deq_ready_i(rdy), .fill_level_o(f16),
      .capacity_o(c16), .empty_o(e16), .full_o(fu16), .overflow_err_o(o16)
   );

   rvv_cmd_queue #(.DATA_W(DW), .DEPTH(13)) u_dut13 (
      .clk(clk), .rst(rst), .flush_i(flush), .enq_count_i(enq_cnt), .enq_data_i(enq_data),
      .deq_valid_o(v13), .deq_data_o(d13), .deq_ready_i(rdy), .fill_level_o(f13),
      .capacity_o(c13), .empty_o(e13), .full_o(fu13), .overflow_err_o(o13)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Expected-entry push at each edge; free space uses the pre-edge occupancy.
   task automatic mdl(input int k, input int depth);
      int free, acc;
      if (rst) begin
         sb_q[k].delete();
         exp_ovf[k] = 1'b0;
      end else if (flush) begin
         sb_q[k].delete();
      end else begin
         free = depth - (sb_q[k].size() + pend_pop[k]);
         acc  = (int'(enq_cnt) < free) ? int'(enq_cnt) : free;
         if (int'(enq_cnt) > free) exp_ovf[k] = 1'b1;
         for (int i = 0; i < acc; i++) sb_q[k].push_back(enq_data[i*DW +: DW]);
      end
      pend_pop[k] = 0;
   endtask

   // Compares what the DUT presents and pops the lanes that handshake at the coming edge.
   task automatic mon(input int k, input int depth, input int fill, input logic [1:0] valid,
                      input logic [63:0] data, input logic emp, input logic ful,
                      input int cap, input logic ovf);
      int          sz, nv, n, ce;
      logic [1:0]  tv;
      string       p;
      p  = $sformatf("d%0d_", depth);
      sz = sb_q[k].size();
      nv = (sz < 2) ? sz : 2;
      tv = 2'((1 << nv) - 1);
      ce = depth - 4 - sz;
      if (ce < 0) ce = 0;
      if (ce > 8) ce = 8;
      chk({p, "fill"}, 64'(fill), 64'(sz));
      chk({p, "valid"}, 64'(valid), 64'(tv));
      chk({p, "empty"}, 64'(emp), 64'(sz == 0));
      chk({p, "full"}, 64'(ful), 64'(sz == depth));
      chk({p, "capacity"}, 64'(cap), 64'(ce));
      chk({p, "overflow"}, 64'(ovf), 64'(exp_ovf[k]));
      for (int i = 0; i < nv; i++) begin
         chk($sformatf("%sdata_lane%0d", p, i), 64'(data[i*DW +: DW]), 64'(sb_q[k][i]));
      end
      n = 0;
      while (n < nv && rdy[n]) n++;
      for (int i = 0; i < n; i++) void'(sb_q[k].pop_front());
      pend_pop[k] = n;
      n_pop[k]   += n;
   endtask

   always @(posedge clk) begin
      mdl(0, 16);
      mdl(1, 13);
   end

   always @(negedge clk) begin
      if (mon_en) begin
         mon(0, 16, int'(f16), v16, d16, e16, fu16, int'(c16), o16);
         mon(1, 13, int'(f13), v13, d13, e13, fu13, int'(c13), o13);
      end
   end

   task automatic step(input int cnt, input logic [127:0] dat, input logic [1:0] r,
                       input logic fl, input logic rs);
      enq_cnt  = 3'(cnt);
      enq_data = dat;
      rdy      = r;
      flush    = fl;
      rst      = rs;
      @(posedge clk);
      #1;
      enq_cnt = '0;
      flush   = 1'b0;
      rst     = 1'b0;
      rdy     = '0;
   endtask

   // Hand-computed status of the DEPTH=16 instance.
   task automatic chk16(input string nm, input int fill, input logic [1:0] valid,
                        input int cap, input logic ovf);
      chk({nm, "_fill"}, 64'(f16), 64'(fill));
      chk({nm, "_valid"}, 64'(v16), 64'(valid));
      chk({nm, "_cap"}, 64'(c16), 64'(cap));
      chk({nm, "_ovf"}, 64'(o16), 64'(ovf));
   endtask

   logic [1:0]   rdy_pat [8] = '{2'b11, 2'b01, 2'b11, 2'b00, 2'b10, 2'b11, 2'b11, 2'b01};
   logic [127:0] dat;

   initial begin
      int sent, cnt, cyc;
      pend_pop = '{0, 0};
      n_pop    = '{0, 0};
      exp_ovf  = '{1'b0, 1'b0};
      rst = 1'b1; flush = 1'b0; enq_cnt = '0; enq_data = '0; rdy = '0;
      @(posedge clk);
      #1;
      rst    = 1'b0;
      mon_en = 1'b1;
      chk16("reset", 0, 2'b00, 8, 1'b0);
      chk("reset_empty", 64'(e16), 64'd1);
      chk("reset_full", 64'(fu16), 64'd0);

      step(4, {32'hD, 32'hC, 32'hB, 32'hA}, 2'b00, 1'b0, 1'b0);
      chk16("enq4", 4, 2'b11, 8, 1'b0);
      chk("enq4_data", 64'(d16), {32'hB, 32'hA});
      step(0, '0, 2'b10, 1'b0, 1'b0);
      chk16("rdy10", 4, 2'b11, 8, 1'b0);
      step(0, '0, 2'b11, 1'b0, 1'b0);
      chk16("deq2", 2, 2'b11, 8, 1'b0);
      chk("deq2_data", 64'(d16), {32'hD, 32'hC});

      for (int n = 0; n < 3; n++) begin
         step(4, {32'(16 + 4*n + 3), 32'(16 + 4*n + 2), 32'(16 + 4*n + 1), 32'(16 + 4*n)},
              2'b00, 1'b0, 1'b0);
      end
      chk16("fill14", 14, 2'b11, 0, 1'b0);
      step(4, {32'h1F, 32'h1E, 32'h1D, 32'h1C}, 2'b00, 1'b0, 1'b0);
      chk16("overfill", 16, 2'b11, 0, 1'b1);
      chk("overfill_full", 64'(fu16), 64'd1);
      step(0, '0, 2'b00, 1'b0, 1'b0);
      chk16("sticky", 16, 2'b11, 0, 1'b1);
      step(2, {64'h0, 32'h21, 32'h20}, 2'b11, 1'b0, 1'b0);
      chk16("full_deq_enq", 14, 2'b11, 0, 1'b1);
      chk("full_deq_enq_data", 64'(d16), {32'h11, 32'h10});

      step(0, '0, 2'b11, 1'b0, 1'b0);
      step(0, '0, 2'b11, 1'b0, 1'b0);
      step(0, '0, 2'b01, 1'b0, 1'b0);
      chk16("fill9", 9, 2'b11, 3, 1'b1);
      step(3, {32'h0, 32'h32, 32'h31, 32'h30}, 2'b11, 1'b1, 1'b0);
      chk16("flush", 0, 2'b00, 8, 1'b1);

      step(0, '0, 2'b00, 1'b0, 1'b1);
      chk16("rst_mid", 0, 2'b00, 8, 1'b0);
      for (int n = 0; n < 4; n++) begin
         step(4, {32'(64 + 4*n + 3), 32'(64 + 4*n + 2), 32'(64 + 4*n + 1), 32'(64 + 4*n)},
              2'b00, 1'b0, 1'b0);
      end
      chk16("fill16", 16, 2'b11, 0, 1'b0);
      step(4, {32'h5, 32'h4, 32'h3, 32'h2}, 2'b00, 1'b1, 1'b0);
      chk16("flush_full", 0, 2'b00, 8, 1'b0);

      n_pop = '{0, 0};
      sent  = 0;
      for (cyc = 0; cyc < 300 && !(sent == 40 && e16 && e13); cyc++) begin
         cnt = (40 - sent < 3) ? 40 - sent : 3;
         if (int'(c16) < cnt) cnt = int'(c16);
         if (int'(c13) < cnt) cnt = int'(c13);
         dat = '0;
         for (int i = 0; i < 3; i++) dat[i*DW +: DW] = 32'(32'h1000 + sent + i);
         step(cnt, dat, rdy_pat[cyc % 8], 1'b0, 1'b0);
         sent += cnt;
      end
      chk("stream_done", 64'(sent == 40 && e16 && e13), 64'd1);
      chk("stream_pop16", 64'(n_pop[0]), 64'd40);
      chk("stream_pop13", 64'(n_pop[1]), 64'd40);

      @(posedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
      $fatal(1, "watchdog expired");
   end

endmodule
